// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-BCD display front end.
// Imported by the converter top and by anything else that drives the 8-digit display.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcdState_e;

    localparam int          BCD_DIGITS  = 8;
    localparam logic [26:0] BCD_MAX     = 27'd99_999_999;
    localparam logic [31:0] OVF_PATTERN = 32'hEEEE_EEEE;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
// Inputs never exceed 9, so the result tops out at 4'hC and never carries.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble converter feeding the seven-segment driver, one shift per clock.
// The result register only changes on completion, so the display never shows partial values.
module bin2bcd_disp
    import display_pkg::*;
#(
    parameter int          BIN_W      = 27,
    parameter logic [3:0]  OVF_NIBBLE = 4'hE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [31:0]      bcd_data
);

    localparam int CNT_W = $clog2(BIN_W);

    bcdState_e        state_q, state_d;
    logic [BIN_W-1:0] shiftReg_q, shiftReg_d;
    logic [31:0]      bcdAcc_q, bcdAcc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovfPend_q, ovfPend_d;
    logic [31:0]      bcdOut_q, bcdOut_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0]      accCorr;
    logic [26:0]      binExt;

    // Zero-extend so the range compare works for every legal BIN_W.
    assign binExt = 27'(bin_data);

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : gAdd3
        bcd_add3 uAdd3 (
            .digit_i (bcdAcc_q[4*g +: 4]),
            .digit_o (accCorr[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bcdAcc_q   <= '0;
            cnt_q      <= '0;
            ovfPend_q  <= 1'b0;
            bcdOut_q   <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bcdAcc_q   <= bcdAcc_d;
            cnt_q      <= cnt_d;
            ovfPend_q  <= ovfPend_d;
            bcdOut_q   <= bcdOut_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bcdAcc_d   = bcdAcc_q;
        cnt_d      = cnt_q;
        ovfPend_d  = ovfPend_q;
        bcdOut_d   = bcdOut_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d = bin_data;
                    bcdAcc_d   = '0;
                    cnt_d      = '0;
                    ovfPend_d  = (binExt > BCD_MAX);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcdAcc_d, shiftReg_d} = {accCorr, shiftReg_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcdOut_d = ovfPend_q ? {BCD_DIGITS{OVF_NIBBLE}} : bcdAcc_q;
                ovf_d    = ovfPend_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign bcd_data = bcdOut_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Bench for bin2bcd_disp: decimal reference model, latency/hold/overflow/reset checks plus random values.
module tb_bin2bcd_disp;

    localparam int BIN_W = 27;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] bin_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [31:0]      bcd_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] lastBcd = '0;
    logic        lastOvf = 1'b0;

    bin2bcd_disp #(
        .BIN_W      (BIN_W),
        .OVF_NIBBLE (4'hE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_data (bin_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .bcd_data (bcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by repeated division; anything past eight digits shows as all E.
    function automatic logic [31:0] refBcd(input longint unsigned v);
        logic [31:0]     res;
        longint unsigned r;
        res = '0;
        r   = v;
        if (v > 64'd99_999_999) return 32'hEEEE_EEEE;
        for (int i = 0; i < 8; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Starts one conversion and follows it to done, checking busy and output hold every cycle.
    // midPulseAt > 0 re-requests with bin_data=42 that many cycles in, which must be ignored.
    task automatic applyStimulus(input logic [BIN_W-1:0] value, input int midPulseAt);
        logic [31:0] expB;
        logic        expO;
        int          lat;
        expB = refBcd(64'(value));
        expO = (64'(value) > 64'd99_999_999);
        bin_data = value;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("holdBcd", bcd_data, lastBcd);
            checkOutput("holdOvf", 32'(ovf), 32'(lastOvf));
            if (n == midPulseAt) begin
                bin_data = 27'd42;
                start    = 1'b1;
            end
        end
        checkOutput("latency", 32'(lat), 32'(BIN_W + 1));
        checkOutput("result", bcd_data, expB);
        checkOutput("ovf", 32'(ovf), 32'(expO));
        checkOutput("busyAtDone", 32'(busy), 32'd0);
        lastBcd = expB;
        lastOvf = expO;
    endtask

    initial begin
        int doneCount;
        logic [BIN_W-1:0] rv;

        rst_n    = 1'b0;
        start    = 1'b0;
        bin_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("rstBcd", bcd_data, 32'h0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstOvf", 32'(ovf), 32'd0);

        applyStimulus(27'd12_345_678, 0);
        checkOutput("hex12345678", bcd_data, 32'h1234_5678);
        @(posedge clk); #1;
        checkOutput("donePulse", 32'(done), 32'd0);

        applyStimulus(27'd0, 0);
        applyStimulus(27'd99_999_999, 0);
        checkOutput("hexMax", bcd_data, 32'h9999_9999);
        applyStimulus(27'd100_000_000, 0);
        checkOutput("hexOvf", bcd_data, 32'hEEEE_EEEE);
        applyStimulus(27'd1_000, 0);

        // Ignored mid-conversion request, then a start accepted on the done cycle.
        applyStimulus(27'd31_415_926, 5);
        applyStimulus(27'd42, 0);
        checkOutput("hex42", bcd_data, 32'h0000_0042);

        applyStimulus(27'd777, 0);
        applyStimulus(27'd555, 0);
        checkOutput("hex555", bcd_data, 32'h0000_0555);

        // Reset partway through a conversion must abort it with no done pulse.
        bin_data = 27'd87_654_321;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midRstBcd", bcd_data, 32'h0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstOvf", 32'(ovf), 32'd0);
        doneCount = 0;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        checkOutput("midRstNoDone", 32'(doneCount), 32'd0);
        lastBcd = '0;
        lastOvf = 1'b0;
        applyStimulus(27'd87_654_321, 0);

        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0) rv = 27'($urandom);
            else            rv = 27'($urandom_range(0, 99_999_999));
            applyStimulus(rv, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
